pipe_cla_add: RTL and testbench

PIPE_CLA_ADD -- requirements
Module: pipe_cla_add

---
 rtl/pipe_cla_add.sv | 142 ++++++++++++++
 tb/tb_pipe_cla_add.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_cla_add.sv
// Pipelined carry-lookahead adder/subtractor resolving CHUNK bits per stage with valid/ready flow control.
// Define PIPE_CLA_ADD_FLAGS_EN to compute and pipeline the ovf/zero flags; otherwise they are tied to 0.
module pipe_cla_add #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ovf,
    output logic             zero
);

    localparam int STAGES = (CHUNK < 1) ? 1 : WIDTH / CHUNK;

    generate
        if (CHUNK < 1) begin : g_bad_chunk
            $error("pipe_cla_add: CHUNK must be at least 1");
        end else if (WIDTH % CHUNK != 0) begin : g_bad_width
            $error("pipe_cla_add: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    logic [STAGES-1:0] v_q, v_d;
    logic [STAGES-1:0] c_q, c_d;
    logic [WIDTH-1:0]  a_q [STAGES];
    logic [WIDTH-1:0]  a_d [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];
    logic [WIDTH-1:0]  b_d [STAGES];
    logic [WIDTH-1:0]  s_q [STAGES];
    logic [WIDTH-1:0]  s_d [STAGES];
    logic              advance;

`ifdef PIPE_CLA_ADD_FLAGS_EN
    logic ovf_d, zero_d;
    logic ovf_q, zero_q;
`endif

    // The whole pipe moves as one; a stalled output freezes every stage.
    assign out_valid = v_q[STAGES-1];
    assign in_ready  = !out_valid || out_ready;
    assign advance   = in_ready;
    assign s         = s_q[STAGES-1];
    assign co        = c_q[STAGES-1];

    always_comb begin
        logic [WIDTH-1:0] a_cur, b_cur, s_cur;
        logic             c_cur, v_cur, pp;
        logic [CHUNK-1:0] p, g;
        logic [CHUNK:0]   cc;
        a_cur = a;
        b_cur = b ^ {WIDTH{sub}};
        c_cur = ci | sub;
        s_cur = '0;
        v_cur = in_valid;
`ifdef PIPE_CLA_ADD_FLAGS_EN
        ovf_d  = 1'b0;
        zero_d = 1'b0;
`endif
        for (int k = 0; k < STAGES; k++) begin
            p  = a_cur[k*CHUNK +: CHUNK] ^ b_cur[k*CHUNK +: CHUNK];
            g  = a_cur[k*CHUNK +: CHUNK] & b_cur[k*CHUNK +: CHUNK];
            cc = '0;
            cc[0] = c_cur;
            // Flat look-ahead: each carry is an OR of generate terms gated by the propagates above them.
            for (int i = 0; i < CHUNK; i++) begin
                cc[i+1] = g[i];
                pp      = p[i];
                for (int j = i - 1; j >= 0; j--) begin
                    cc[i+1] = cc[i+1] | (pp & g[j]);
                    pp      = pp & p[j];
                end
                cc[i+1] = cc[i+1] | (pp & c_cur);
            end
            s_cur[k*CHUNK +: CHUNK] = p ^ cc[CHUNK-1:0];
            v_d[k] = v_cur;
            a_d[k] = a_cur;
            b_d[k] = b_cur;
            s_d[k] = s_cur;
            c_d[k] = cc[CHUNK];
`ifdef PIPE_CLA_ADD_FLAGS_EN
            if (k == STAGES - 1) begin
                ovf_d  = (a_cur[WIDTH-1] == b_cur[WIDTH-1]) && (s_cur[WIDTH-1] != a_cur[WIDTH-1]);
                zero_d = (s_cur == '0);
            end
`endif
            v_cur = v_q[k];
            a_cur = a_q[k];
            b_cur = b_q[k];
            s_cur = s_q[k];
            c_cur = c_q[k];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q <= '0;
            c_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
        end else if (advance) begin
            v_q <= v_d;
            c_q <= c_d;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= a_d[k];
                b_q[k] <= b_d[k];
                s_q[k] <= s_d[k];
            end
        end
    end

`ifdef PIPE_CLA_ADD_FLAGS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (advance) begin
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
        end
    end

    assign ovf  = ovf_q;
    assign zero = zero_q;
`else
    assign ovf  = 1'b0;
    assign zero = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_cla_add.sv
// Self-checking bench for pipe_cla_add: random and directed operations against an arithmetic reference model.
module tb_pipe_cla_add;

    localparam int STAGES = 4;
`ifdef PIPE_CLA_ADD_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, in_valid, in_ready, ci, sub, out_valid, out_ready, co, ovf, zero;
    logic [15:0] a, b, s;

    logic        w_in_valid, w_in_ready, w_ci, w_sub, w_out_valid, w_out_ready, w_co, w_ovf, w_zero;
    logic [31:0] w_a, w_b, w_s;

    pipe_cla_add dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .ci(ci), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .s(s), .co(co), .ovf(ovf), .zero(zero)
    );

    pipe_cla_add #(.WIDTH(32), .CHUNK(8)) wdut (
        .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready),
        .a(w_a), .b(w_b), .ci(w_ci), .sub(w_sub),
        .out_valid(w_out_valid), .out_ready(w_out_ready),
        .s(w_s), .co(w_co), .ovf(w_ovf), .zero(w_zero)
    );

    typedef struct {
        logic [15:0] s;
        logic        co;
        logic        ovf;
        logic        zero;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    bit          lat_check = 1'b0;
    bit          prev_stall = 1'b0;
    logic [15:0] last_s;
    logic        last_co, last_ovf, last_zero;
    int          last_lat;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        if (obs !== expv) begin
            failures++;
            $display("[TB] FAIL %s got=%0h expected=%0h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    // Plain arithmetic: a + (b or ~b) + carry, with flags derived from operand and result signs.
    function automatic exp_t refModel(input logic [15:0] x, input logic [15:0] y,
                                      input logic cin, input logic op_sub);
        logic [15:0] yp;
        logic [16:0] full;
        exp_t        e;
        yp     = op_sub ? ~y : y;
        full   = 17'(x) + 17'(yp) + 17'(cin | op_sub);
        e.s    = full[15:0];
        e.co   = full[16];
        e.ovf  = FLAGS && (x[15] == yp[15]) && (full[15] != x[15]);
        e.zero = FLAGS && (full[15:0] == 16'h0000);
        e.cyc  = cyc;
        return e;
    endfunction

    task automatic applyStimulus(input logic iv, input logic [15:0] ia, input logic [15:0] ib,
                                 input logic ici, input logic isub, input logic iordy);
        exp_t e;
        in_valid  = iv;
        a         = ia;
        b         = ib;
        ci        = ici;
        sub       = isub;
        out_ready = iordy;
        #1;
        checkOutput("in_ready", in_ready, !(out_valid && !out_ready));
        if (prev_stall) checkOutput("hold_valid", out_valid, 1);
        if (out_valid && sb.size() == 0) checkOutput("spurious_valid", out_valid, 0);
        if (out_valid && !out_ready && sb.size() > 0) begin
            checkOutput("hold_s", s, sb[0].s);
            checkOutput("hold_co", co, sb[0].co);
        end
        if (out_valid && out_ready && sb.size() > 0) begin
            e = sb.pop_front();
            checkOutput("s", s, e.s);
            checkOutput("co", co, e.co);
            checkOutput("ovf", ovf, e.ovf);
            checkOutput("zero", zero, e.zero);
            last_s    = s;
            last_co   = co;
            last_ovf  = ovf;
            last_zero = zero;
            last_lat  = cyc - e.cyc;
            if (lat_check) checkOutput("latency", last_lat, STAGES);
        end
        if (iv && in_ready) sb.push_back(refModel(ia, ib, ici, isub));
        prev_stall = out_valid && !out_ready;
        @(negedge clk);
        cyc++;
    endtask

    task automatic doReset(input int n);
        rst      = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (n) begin
            @(negedge clk);
            cyc++;
        end
        rst = 1'b0;
        sb.delete();
        prev_stall = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb.size() > 0; i++) applyStimulus(0, 16'h0, 16'h0, 0, 0, 1);
        checkOutput("drain_empty", sb.size(), 0);
        repeat (2) applyStimulus(0, 16'h0, 16'h0, 0, 0, 1);
    endtask

    initial begin
        int lat;
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; ci = 1'b0; sub = 1'b0; out_ready = 1'b1;
        w_in_valid = 1'b0; w_a = '0; w_b = '0; w_ci = 1'b0; w_sub = 1'b0; w_out_ready = 1'b1;
        @(negedge clk);
        doReset(2);
        #1;
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_s", s, 0);
        checkOutput("rst_co", co, 0);
        checkOutput("rst_ovf", ovf, 0);
        checkOutput("rst_zero", zero, 0);
        checkOutput("rst_in_ready", in_ready, 1);

        lat_check = 1'b1;
        applyStimulus(1, 16'h7FFF, 16'h0001, 0, 0, 1);
        drain();
        checkOutput("ovf_case_s", last_s, 16'h8000);
        checkOutput("ovf_case_co", last_co, 0);
        checkOutput("ovf_case_ovf", last_ovf, FLAGS);
        checkOutput("ovf_case_zero", last_zero, 0);

        applyStimulus(1, 16'h1234, 16'h1234, 0, 1, 1);
        drain();
        checkOutput("sub_eq_s", last_s, 16'h0000);
        checkOutput("sub_eq_co", last_co, 1);
        checkOutput("sub_eq_ovf", last_ovf, 0);
        checkOutput("sub_eq_zero", last_zero, FLAGS);

        for (int i = 0; i < 8; i++)
            applyStimulus(1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1);
        drain();

        lat_check = 1'b0;
        for (int i = 0; i < 60; i++)
            applyStimulus(1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
                          1'($urandom_range(0, 3) != 0));
        drain();

        for (int i = 0; i < 7; i++)
            applyStimulus(1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 0);
        checkOutput("stall_in_ready", in_ready, 0);
        checkOutput("stall_full", sb.size(), STAGES);
        for (int i = 0; i < 4; i++)
            applyStimulus(1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1);
        drain();

        lat_check = 1'b1;
        for (int i = 0; i < 3; i++)
            applyStimulus(1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1);
        doReset(1);
        #1;
        checkOutput("midrst_out_valid", out_valid, 0);
        checkOutput("midrst_in_ready", in_ready, 1);
        for (int i = 0; i < 6; i++) begin
            checkOutput("midrst_quiet", out_valid, 0);
            applyStimulus(0, 16'h0, 16'h0, 0, 0, 1);
        end
        applyStimulus(1, 16'hFFFF, 16'h0001, 0, 0, 1);
        drain();
        checkOutput("after_rst_s", last_s, 16'h0000);
        checkOutput("after_rst_co", last_co, 1);

        w_a = 32'hFFFF_FFFF; w_b = 32'h0000_0000; w_ci = 1'b1; w_sub = 1'b0; w_in_valid = 1'b1;
        #1;
        checkOutput("wide_in_ready", w_in_ready, 1);
        @(negedge clk);
        cyc++;
        w_in_valid = 1'b0;
        lat = 1;
        while (lat <= 10) begin
            #1;
            if (w_out_valid) break;
            @(negedge clk);
            cyc++;
            lat++;
        end
        checkOutput("wide_latency", lat, 4);
        checkOutput("wide_s", w_s, 32'h0000_0000);
        checkOutput("wide_co", w_co, 1);
        checkOutput("wide_zero", w_zero, FLAGS);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout got=running expected=finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
